// File: rtl/radix2_butterfly.sv
// Radix-2 DIT butterfly: pairs consecutive valid samples (a, b), multiplies b by the
// Q2.12 twiddle and emits X0 = a + bW then X1 = a - bW on consecutive cycles.
module radix2_butterfly #(
    parameter int bit_width = 29,
    parameter int N         = 16,
    parameter int SIZE      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en_radix,
    input  logic signed [bit_width-1:0] Re_i,
    input  logic signed [bit_width-1:0] Im_i,
    input  logic signed [13:0]          cos_data,
    input  logic signed [13:0]          sin_data,
    output logic signed [bit_width+1:0] Re_o,
    output logic signed [bit_width+1:0] Im_o,
    output logic                        en_o,
    output logic                        sel_o,
    output logic                        done_o
);

    localparam int PW     = bit_width + 14;
    localparam int STAGES = 2;
    localparam logic [SIZE-2:0] LAST = (SIZE-1)'(N/2 - 1);

    logic                        ph;
    logic [STAGES:0]             vld_pipe;
    logic [SIZE-2:0]             cnt;

    logic signed [bit_width-1:0] a_re, a_im, b_re, b_im, a_re_d, a_im_d;
    logic signed [13:0]          w_c, w_s;
    logic signed [bit_width:0]   t_re, t_im;
    logic signed [bit_width+1:0] x0_re, x0_im, x1_re, x1_im;

    logic signed [PW-1:0]        p_rc, p_is, p_rs, p_ic;
    logic signed [PW:0]          pr, pi;

    always_comb begin
        p_rc  = PW'(b_re) * PW'(w_c);
        p_is  = PW'(b_im) * PW'(w_s);
        p_rs  = PW'(b_re) * PW'(w_s);
        p_ic  = PW'(b_im) * PW'(w_c);
        pr    = (PW+1)'(p_rc) - (PW+1)'(p_is);
        pi    = (PW+1)'(p_rs) + (PW+1)'(p_ic);
        x0_re = (bit_width+2)'(a_re_d) + (bit_width+2)'(t_re);
        x0_im = (bit_width+2)'(a_im_d) + (bit_width+2)'(t_im);
    end

    // Datapath registers carry no reset; the valid pipe decides what is meaningful.
    always_ff @(posedge clk) begin
        if (en_radix && !ph) begin
            a_re <= Re_i;
            a_im <= Im_i;
        end
        if (en_radix && ph) begin
            b_re <= Re_i;
            b_im <= Im_i;
            w_c  <= cos_data;
            w_s  <= sin_data;
        end
        if (vld_pipe[0]) begin
            t_re   <= (bit_width+1)'(pr >>> 12);
            t_im   <= (bit_width+1)'(pi >>> 12);
            a_re_d <= a_re;
            a_im_d <= a_im;
        end
        if (vld_pipe[1]) begin
            x1_re <= (bit_width+2)'(a_re_d) - (bit_width+2)'(t_re);
            x1_im <= (bit_width+2)'(a_im_d) - (bit_width+2)'(t_im);
        end
    end

    // Launches are at least two cycles apart, so X0 and X1 slots never collide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph       <= 1'b0;
            vld_pipe <= '0;
            cnt      <= '0;
            Re_o     <= '0;
            Im_o     <= '0;
            en_o     <= 1'b0;
            sel_o    <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            if (en_radix)
                ph <= ~ph;
            vld_pipe <= {vld_pipe[STAGES-1:0], en_radix & ph};
            en_o     <= 1'b0;
            sel_o    <= 1'b0;
            done_o   <= 1'b0;
            if (vld_pipe[1]) begin
                Re_o <= x0_re;
                Im_o <= x0_im;
                en_o <= 1'b1;
            end else if (vld_pipe[2]) begin
                Re_o   <= x1_re;
                Im_o   <= x1_im;
                en_o   <= 1'b1;
                sel_o  <= 1'b1;
                done_o <= (cnt == LAST);
                cnt    <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_radix2_butterfly.sv
// Scoreboard bench for radix2_butterfly: directed butterflies push expected X0/X1 with
// their due cycle; a negedge monitor pops and compares whenever en_o is high.
module tb_radix2_butterfly;

    localparam int BW = 29;

    logic                 clk, rst_n, en_radix;
    logic signed [BW-1:0] Re_i, Im_i;
    logic signed [13:0]   cos_data, sin_data;
    logic signed [BW+1:0] Re_o, Im_o;
    logic                 en_o, sel_o, done_o;

    radix2_butterfly #(.bit_width(BW), .N(16), .SIZE(4)) dut (
        .clk(clk), .rst_n(rst_n), .en_radix(en_radix),
        .Re_i(Re_i), .Im_i(Im_i), .cos_data(cos_data), .sin_data(sin_data),
        .Re_o(Re_o), .Im_o(Im_o), .en_o(en_o), .sel_o(sel_o), .done_o(done_o)
    );

    typedef struct {
        logic signed [BW+1:0] re;
        logic signed [BW+1:0] im;
        logic                 sel;
        logic                 done;
        int                   cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   tb_cnt = 0;
    bit   mon_on = 0;

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            if (en_o === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output cyc=%0d re=%0d im=%0d sel=%0b", cyc, Re_o, Im_o, sel_o);
                end else begin
                    e = q.pop_front();
                    if (Re_o !== e.re || Im_o !== e.im || sel_o !== e.sel ||
                        done_o !== e.done || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL output got re=%0d im=%0d sel=%0b done=%0b cyc=%0d want re=%0d im=%0d sel=%0b done=%0b cyc=%0d",
                                 Re_o, Im_o, sel_o, done_o, cyc, e.re, e.im, e.sel, e.done, e.cyc);
                    end
                end
            end else begin
                checks++;
                if (en_o !== 1'b0 || sel_o !== 1'b0 || done_o !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_flags cyc=%0d got en=%0b sel=%0b done=%0b want 0 0 0", cyc, en_o, sel_o, done_o);
                end
            end
        end
    end

    task automatic put(input bit en, input int re, input int im, input int c, input int s);
        @(negedge clk);
        en_radix = en;
        Re_i     = BW'(re);
        Im_i     = BW'(im);
        cos_data = 14'(c);
        sin_data = 14'(s);
    endtask

    task automatic push(input int re, input int im, input logic sel, input logic done, input int at);
        exp_t e;
        e.re = (BW+2)'(re);
        e.im = (BW+2)'(im);
        e.sel = sel;
        e.done = done;
        e.cyc = at;
        q.push_back(e);
    endtask

    // b is sampled on the edge after this negedge; X0 is visible 3 negedges later.
    task automatic bfly(input int ar, input int ai, input int br, input int bi,
                        input int c, input int s, input int gap,
                        input int x0r, input int x0i, input int x1r, input int x1i);
        put(1, ar, ai, 0, 0);
        repeat (gap) put(0, 0, 0, 0, 0);
        put(1, br, bi, c, s);
        push(x0r, x0i, 1'b0, 1'b0, cyc + 3);
        push(x1r, x1i, 1'b1, tb_cnt == 7, cyc + 4);
        tb_cnt = (tb_cnt + 1) % 8;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        en_radix = 1'b0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d want 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (Re_o !== '0 || Im_o !== '0 || en_o !== 1'b0 || sel_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL %s got re=%0d im=%0d en=%0b sel=%0b done=%0b want all 0",
                     name, Re_o, Im_o, en_o, sel_o, done_o);
        end
    endtask

    initial begin
        rst_n = 0; en_radix = 0; Re_i = '0; Im_i = '0; cos_data = '0; sin_data = '0;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst_n = 1;
        mon_on = 1;

        // Two back-to-back passes: identity twiddle, then -j twiddle.
        for (int p = 0; p < 8; p++)
            bfly(100*p, -p, p+1, 2*p, 4096, 0, 0, 101*p+1, p, 99*p-1, -3*p);
        for (int p = 0; p < 8; p++)
            bfly(100*p, -p, p+1, 2*p, 0, -4096, 0, 102*p, -2*p-1, 98*p, 1);
        drain();

        bfly(100, 0, 50, 0, 4096, 0, 0, 150, 0, 50, 0);
        bfly(100, 0, 50, 0, 0, -4096, 0, 100, -50, 100, 50);
        bfly(0, 0, 1000, 0, 3784, -1567, 0, 923, -383, -923, 383);
        drain();
        bfly(100, 0, 50, 0, 4096, 0, 3, 150, 0, 50, 0);
        bfly(-7, 9, -3, -1, 4096, 0, 1, -10, 8, -4, 10);
        drain();

        // Reset with a half-captured pair; outputs currently hold a nonzero X1.
        put(1, 500, 7, 0, 0);
        @(negedge clk);
        rst_n = 0;
        en_radix = 0;
        tb_cnt = 0;
        @(negedge clk);
        check_zero("reset_mid_pair");
        rst_n = 1;
        bfly(10, 20, 3, 4, 4096, 0, 0, 13, 24, 7, 16);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/radix2_butterfly.md
# radix2_butterfly

Radix-2 decimation-in-time butterfly stage that directly consumes the sample/twiddle stream produced by the bit-reversed sample RAM. It pairs consecutive valid samples (a, b) and multiplies b by the twiddle W presented with it. It then emits X0 = a + b·W and X1 = a − b·W serially on two consecutive cycles. It also counts butterflies and pulses a done flag when one pass of N/2 butterflies completes.

## Interface
- bit_width, 29, width of incoming real/imag samples (signed)
- N, 16, transform length; one pass = N/2 butterflies
- SIZE, 4, log2(N); the pair counter is SIZE-1 bits
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous and active-low
- en_radix  in  1  input sample valid; Re_i/Im_i/cos_data/sin_data are sampled when high
- Re_i  in  bit_width  signed real part of the sample
- Im_i  in  bit_width  signed imaginary part of the sample
- cos_data  in  14  signed twiddle real part, Q2.12 (4096 = 1.0)
- sin_data  in  14  signed twiddle imaginary part, Q2.12 (stored negative, W = e^−jθ)
- Re_o  out  bit_width+2  signed butterfly output, real part
- Im_o  out  bit_width+2  signed butterfly output, imaginary part
- en_o  out  1  output valid; high for X0 then X1
- sel_o  out  1  0 = X0 on outputs, 1 = X1 on outputs
- done_o  out  1  one-cycle pulse, coincident with X1 of butterfly N/2−1 of a pass

## Operation
- Capture phase bit `ph` (reset 0); it toggles only on cycles where en_radix = 1.
  - ph = 0: register a = (Re_i, Im_i). The twiddle is ignored.
  - ph = 1: register b = (Re_i, Im_i) together with W = (cos_data, sin_data), and launch the butterfly.
- Gaps: en_radix may drop at any point, including between a and b. State holds, and the pair completes on the next valid sample.
- Multiply stage, one cycle after launch:
  - Full-precision products, each bit_width+14 bits.
  - pr = Re_b·cos − Im_b·sin
  - pi = Re_b·sin + Im_b·cos
  - T = (pr, pi) >>> 12, arithmetic shift (floor, no rounding), kept at bit_width+1 bits. Cannot overflow since |W| ≤ 1.
  - a is delayed alongside T.
- Output stage:
  - Cycle 1: X0 = a + T, sign-extended to bit_width+2; en_o = 1, sel_o = 0.
  - Next cycle: X1 = a − T; en_o = 1, sel_o = 1.
  - No saturation is needed; widths guarantee no wrap.
- Pair counter (SIZE−1 bits, reset 0):
  - Increments as X1 is emitted.
  - done_o = 1 when X1 is emitted with counter = N/2−1.
  - The counter then wraps to 0, so the next pass follows seamlessly.
- Reset, or rst_n low mid-operation:
  - ph, the pipeline valids, and the counter clear to 0.
  - Re_o = Im_o = 0, en_o = 0, sel_o = 0, done_o = 0.
  - Any half-captured pair or in-flight butterfly is discarded. The first valid sample after reset is treated as a.

## Timing
- Launch: b sampled at edge k.
- T is registered at edge k+1.
- X0 appears on the outputs after edge k+2; X1 after edge k+3.
- Latency from b to X0 is 2 cycles.
- Throughput is one butterfly per 2 cycles. Fully back-to-back input (en_radix held high) produces a continuous en_o stream with sel_o alternating 0,1 and no stall; no backpressure exists.
- Outputs are registered. When en_o = 0, Re_o/Im_o hold their last value and sel_o = 0.
- en_radix at the same edge as an output emission is accepted normally; capture and emission are independent.
- rst_n is sampled at the edge and overrides every other event in that cycle.

## Test plan
- Identity twiddle: a = (100, 0), b = (50, 0), W = (4096, 0).
  - Expect X0 = (150, 0), then X1 = (50, 0).
  - en_o high for 2 cycles starting 2 cycles after b.
- −j twiddle: a = (100, 0), b = (50, 0), W = (0, −4096).
  - Expect X0 = (100, −50), X1 = (100, 50).
- Truncation: a = (0, 0), b = (1000, 0), W = (3784, −1567).
  - Expect X0 = (923, −383), X1 = (−923, 383).
- Gapped input: a, then 3 idle cycles, then b (identity twiddle).
  - Result equals the no-gap case.
  - en_o rises exactly 2 cycles after b.
- Full pass: 16 back-to-back samples.
  - Continuous en_o for 16 cycles.
  - done_o pulses exactly once, on the 16th output (X1 of pair 7).
  - A second pass repeats the same behaviour.
- Reset mid-pair: a captured, rst_n low for 1 cycle, then samples c, d.
  - Output is the butterfly of (c, d), not of a.
  - All outputs are 0 while in reset.
